// File: rtl/jmr_branch_sequencer.sv
// rtl/jmr_branch_sequencer.sv - PC sequencer applying JMR jump decisions to the fetch stream.
// Optional macro JMR_LINK_EN adds the LINK return-address output.
module jmr_branch_sequencer #(
  parameter int                ADDR_W       = 16,
  parameter logic [ADDR_W-1:0] RESET_PC     = 16'h0000,
  parameter int                FLUSH_CYCLES = 2
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              INSTR_VALID,
  input  logic              IS_JMR,
  input  logic              JUMP,
  input  logic [ADDR_W-1:0] TARGET,
  input  logic              STALL,
  input  logic              HALT_REQ,
  input  logic              RESUME,
  output logic [ADDR_W-1:0] PC,
  output logic              FETCH_EN,
  output logic              FLUSH,
  output logic              HALTED,
  output logic [15:0]       JUMP_COUNT
`ifdef JMR_LINK_EN
  ,
  output logic [ADDR_W-1:0] LINK
`endif
);

  typedef enum logic [1:0] {
    S_BOOT   = 2'd0,
    S_RUN    = 2'd1,
    S_FLUSH  = 2'd2,
    S_HALTED = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [15:0]       count_q, count_d;
  logic              flush_q, halted_q;
  logic [ADDR_W-1:0] link_q, link_d;
  logic              taken;

  assign taken = INSTR_VALID & IS_JMR & JUMP;

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    cnt_d   = cnt_q;
    count_d = count_q;
    link_d  = link_q;
    case (state_q)
      S_BOOT: state_d = S_RUN;
      S_RUN: begin
        if (!STALL) begin
          if (taken) begin
            pc_d    = TARGET;
            link_d  = pc_q + ADDR_W'(1);
            count_d = (count_q == 16'hFFFF) ? count_q : count_q + 16'd1;
            cnt_d   = 4'(FLUSH_CYCLES - 1);
            // A halt arriving with a taken jump still commits the jump but skips the flush.
            state_d = HALT_REQ ? S_HALTED : S_FLUSH;
          end else begin
            if (INSTR_VALID) pc_d = pc_q + ADDR_W'(1);
            if (HALT_REQ) state_d = S_HALTED;
          end
        end
      end
      S_FLUSH: begin
        if (!STALL) begin
          if (cnt_q == 4'd0) state_d = S_RUN;
          else               cnt_d   = cnt_q - 4'd1;
        end
      end
      S_HALTED: begin
        if (!STALL && RESUME) state_d = S_RUN;
      end
      default: state_d = S_BOOT;
    endcase
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q  <= S_BOOT;
      pc_q     <= RESET_PC;
      cnt_q    <= 4'd0;
      count_q  <= 16'd0;
      link_q   <= '0;
      flush_q  <= 1'b0;
      halted_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      cnt_q    <= cnt_d;
      count_q  <= count_d;
      link_q   <= link_d;
      flush_q  <= (state_d == S_FLUSH);
      halted_q <= (state_d == S_HALTED);
    end
  end

  assign PC         = pc_q;
  assign FLUSH      = flush_q;
  assign HALTED     = halted_q;
  assign JUMP_COUNT = count_q;
  assign FETCH_EN   = (state_q == S_RUN) && !STALL;

`ifdef JMR_LINK_EN
  assign LINK = link_q;
`else
  logic unused_link;
  assign unused_link = ^link_q;
`endif

endmodule

// File: tb/tb_jmr_branch_sequencer.sv
// tb/tb_jmr_branch_sequencer.sv - table, directed and randomized checks of jmr_branch_sequencer.
module tb_jmr_branch_sequencer;
  localparam int FC = 2;

  logic        CLK = 1'b0;
  logic        RESET, INSTR_VALID, IS_JMR, JUMP, STALL, HALT_REQ, RESUME;
  logic [15:0] TARGET, PC, JUMP_COUNT;
  logic        FETCH_EN, FLUSH, HALTED;
`ifdef JMR_LINK_EN
  logic [15:0] LINK;
`endif

  int checks = 0;
  int failures = 0;

  always #5 CLK = ~CLK;

  jmr_branch_sequencer #(.ADDR_W(16), .RESET_PC(16'h0000), .FLUSH_CYCLES(FC)) dut (
    .CLK(CLK), .RESET(RESET), .INSTR_VALID(INSTR_VALID), .IS_JMR(IS_JMR), .JUMP(JUMP),
    .TARGET(TARGET), .STALL(STALL), .HALT_REQ(HALT_REQ), .RESUME(RESUME),
    .PC(PC), .FETCH_EN(FETCH_EN), .FLUSH(FLUSH), .HALTED(HALTED), .JUMP_COUNT(JUMP_COUNT)
`ifdef JMR_LINK_EN
    , .LINK(LINK)
`endif
  );

  typedef enum {M_BOOT, M_RUN, M_FLUSH, M_HALT} mode_t;
  mode_t       m_mode;
  logic [15:0] m_pc, m_cnt, m_link;
  int          m_left;

  typedef struct {
    logic v, j, jmp; logic [15:0] tgt; logic st, hr, rs;
    logic fe; logic [15:0] pc; logic fl, ha; logic [15:0] cnt;
  } vec_t;
  vec_t tbl[$];

  task automatic chk(string tag, string field, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s.%s actual=%0h required=%0h", tag, field, act, exp);
    end
  endtask

  task automatic add(logic v, logic j, logic jmp, logic [15:0] tgt, logic st, logic hr, logic rs,
                     logic fe, logic [15:0] pc, logic fl, logic ha, logic [15:0] cnt);
    vec_t r;
    r.v = v; r.j = j; r.jmp = jmp; r.tgt = tgt; r.st = st; r.hr = hr; r.rs = rs;
    r.fe = fe; r.pc = pc; r.fl = fl; r.ha = ha; r.cnt = cnt;
    tbl.push_back(r);
  endtask

  task automatic drive(logic v, logic j, logic jmp, logic [15:0] tgt, logic st, logic hr, logic rs);
    INSTR_VALID = v; IS_JMR = j; JUMP = jmp; TARGET = tgt; STALL = st; HALT_REQ = hr; RESUME = rs;
  endtask

  task automatic model_reset();
    m_mode = M_BOOT; m_pc = 16'h0000; m_cnt = 16'h0000; m_link = 16'h0000; m_left = 0;
  endtask

  // Reference behaviour: one call per rising edge, using the inputs present at that edge.
  task automatic model_step();
    if (m_mode == M_BOOT) m_mode = M_RUN;
    else if (!STALL) begin
      case (m_mode)
        M_RUN: begin
          if (INSTR_VALID && IS_JMR && JUMP) begin
            m_link = m_pc + 16'd1;
            m_pc   = TARGET;
            if (m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
            m_left = FC;
            m_mode = HALT_REQ ? M_HALT : M_FLUSH;
          end else begin
            if (INSTR_VALID) m_pc = m_pc + 16'd1;
            if (HALT_REQ) m_mode = M_HALT;
          end
        end
        M_FLUSH: begin
          m_left = m_left - 1;
          if (m_left == 0) m_mode = M_RUN;
        end
        M_HALT: if (RESUME) m_mode = M_RUN;
        default: ;
      endcase
    end
  endtask

  task automatic check_model(string tag);
    chk(tag, "pc", PC, m_pc);
    chk(tag, "flush", FLUSH, m_mode == M_FLUSH);
    chk(tag, "halted", HALTED, m_mode == M_HALT);
    chk(tag, "jump_count", JUMP_COUNT, m_cnt);
`ifdef JMR_LINK_EN
    chk(tag, "link", LINK, m_link);
`endif
  endtask

  task automatic cycle(string tag);
    #1 chk(tag, "fetch_en", FETCH_EN, (m_mode == M_RUN) && !STALL);
    @(posedge CLK);
    model_step();
    @(negedge CLK);
    check_model(tag);
  endtask

  initial begin
    RESET = 1'b1;
    drive(0, 0, 0, 16'h0, 0, 0, 0);
    model_reset();
    repeat (3) @(negedge CLK);
    chk("reset", "pc", PC, 16'h0000);
    chk("reset", "fetch_en", FETCH_EN, 1'b0);
    chk("reset", "flush", FLUSH, 1'b0);
    chk("reset", "halted", HALTED, 1'b0);
    chk("reset", "jump_count", JUMP_COUNT, 16'h0000);
    RESET = 1'b0;

    //  v  j  jmp tgt       st hr rs   fe pc       fl ha cnt
    add(0, 0, 0, 16'h0000, 1, 0, 0,   0, 16'h0000, 0, 0, 0);
    for (int i = 1; i <= 5; i++)
      add(1, 0, 0, 16'h0000, 0, 0, 0, 1, 16'(i), 0, 0, 0);
    add(1, 1, 1, 16'h1234, 0, 0, 0,   1, 16'h1234, 1, 0, 1);
    add(1, 0, 0, 16'h0000, 0, 0, 0,   0, 16'h1234, 1, 0, 1);
    add(1, 1, 1, 16'h7777, 0, 0, 0,   0, 16'h1234, 0, 0, 1);
    add(0, 0, 0, 16'h0000, 0, 0, 0,   1, 16'h1234, 0, 0, 1);
    add(1, 1, 1, 16'hFFFF, 0, 0, 0,   1, 16'hFFFF, 1, 0, 2);
    add(0, 0, 0, 16'h0000, 1, 0, 0,   0, 16'hFFFF, 1, 0, 2);
    add(0, 0, 0, 16'h0000, 0, 1, 0,   0, 16'hFFFF, 1, 0, 2);
    add(0, 0, 0, 16'h0000, 0, 0, 0,   0, 16'hFFFF, 0, 0, 2);
    add(1, 1, 0, 16'h5555, 0, 0, 0,   1, 16'h0000, 0, 0, 2);
    for (int i = 0; i < 3; i++)
      add(1, 1, 1, 16'h0ABC, 1, 0, 0, 0, 16'h0000, 0, 0, 2);
    add(1, 1, 1, 16'h0ABC, 0, 0, 0,   1, 16'h0ABC, 1, 0, 3);
    add(0, 0, 0, 16'h0000, 0, 0, 0,   0, 16'h0ABC, 1, 0, 3);
    add(0, 0, 0, 16'h0000, 0, 0, 0,   0, 16'h0ABC, 0, 0, 3);
    add(1, 1, 1, 16'h2000, 0, 1, 0,   1, 16'h2000, 0, 1, 4);
    add(1, 0, 0, 16'h0000, 0, 1, 0,   0, 16'h2000, 0, 1, 4);
    add(0, 0, 0, 16'h0000, 0, 1, 1,   0, 16'h2000, 0, 0, 4);
    add(1, 0, 0, 16'h0000, 0, 0, 0,   1, 16'h2001, 0, 0, 4);
    add(1, 0, 0, 16'h0000, 0, 1, 0,   1, 16'h2002, 0, 1, 4);
    add(0, 0, 0, 16'h0000, 0, 0, 1,   0, 16'h2002, 0, 0, 4);

    foreach (tbl[k]) begin
      drive(tbl[k].v, tbl[k].j, tbl[k].jmp, tbl[k].tgt, tbl[k].st, tbl[k].hr, tbl[k].rs);
      #1 chk($sformatf("vec%0d", k), "fetch_en", FETCH_EN, tbl[k].fe);
      @(posedge CLK);
      model_step();
      @(negedge CLK);
      chk($sformatf("vec%0d", k), "pc", PC, tbl[k].pc);
      chk($sformatf("vec%0d", k), "flush", FLUSH, tbl[k].fl);
      chk($sformatf("vec%0d", k), "halted", HALTED, tbl[k].ha);
      chk($sformatf("vec%0d", k), "jump_count", JUMP_COUNT, tbl[k].cnt);
`ifdef JMR_LINK_EN
      if (k == 6) chk("vec6", "link", LINK, 16'h0006);
`endif
    end

    // Asynchronous reset landing in the middle of a flush.
    drive(1, 1, 1, 16'h4444, 0, 0, 0);
    cycle("rst_jump");
    drive(0, 0, 0, 16'h0, 0, 0, 0);
    #2 RESET = 1'b1;
    #1;
    chk("rst_mid", "pc", PC, 16'h0000);
    chk("rst_mid", "flush", FLUSH, 1'b0);
    chk("rst_mid", "jump_count", JUMP_COUNT, 16'h0000);
    chk("rst_mid", "halted", HALTED, 1'b0);
    chk("rst_mid", "fetch_en", FETCH_EN, 1'b0);
    @(negedge CLK);
    RESET = 1'b0;
    model_reset();
    cycle("reboot");

    // Counter saturation: preload near the top, then three taken jumps.
    force dut.count_q = 16'hFFFD;
    #1 release dut.count_q;
    m_cnt = 16'hFFFD;
    for (int i = 0; i < 3; i++) begin
      drive(1, 1, 1, 16'(16'h3000 + i), 0, 0, 0);
      cycle("sat_jump");
      drive(0, 0, 0, 16'h0, 0, 0, 0);
      repeat (FC) cycle("sat_flush");
    end
    chk("sat", "jump_count", JUMP_COUNT, 16'hFFFF);

    for (int n = 0; n < 3000; n++) begin
      drive($urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1,
            ($urandom_range(0, 7) == 0) ? 16'hFFFF : 16'($urandom),
            $urandom_range(0, 4) == 0, $urandom_range(0, 9) == 0, $urandom_range(0, 2) == 0);
      cycle("rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
